// File: rtl/shift_unit_arbiter_if.sv
// rtl/shift_unit_arbiter_if.sv - request, response and counter bundle for the shared shift unit
interface shift_unit_arbiter_if #(
   parameter int TAG_W = 4,
   parameter int CNT_W = 16
);
   logic             r0_valid;
   logic             r0_ready;
   logic [31:0]      r0_data;
   logic [4:0]       r0_shamt;
   logic             r0_op;
   logic [TAG_W-1:0] r0_tag;

   logic             r1_valid;
   logic             r1_ready;
   logic [31:0]      r1_data;
   logic [4:0]       r1_shamt;
   logic             r1_op;
   logic [TAG_W-1:0] r1_tag;

   logic             rsp0_valid;
   logic             rsp1_valid;
   logic [31:0]      rsp_data;
   logic [TAG_W-1:0] rsp_tag;

   logic [CNT_W-1:0] gnt_cnt0;
   logic [CNT_W-1:0] gnt_cnt1;

   modport master (
      output r0_valid, r0_data, r0_shamt, r0_op, r0_tag,
      output r1_valid, r1_data, r1_shamt, r1_op, r1_tag,
      input  r0_ready, r1_ready,
      input  rsp0_valid, rsp1_valid, rsp_data, rsp_tag,
      input  gnt_cnt0, gnt_cnt1
   );

   modport slave (
      input  r0_valid, r0_data, r0_shamt, r0_op, r0_tag,
      input  r1_valid, r1_data, r1_shamt, r1_op, r1_tag,
      output r0_ready, r1_ready,
      output rsp0_valid, rsp1_valid, rsp_data, rsp_tag,
      output gnt_cnt0, gnt_cnt1
   );
endinterface

// File: rtl/shift_unit_arbiter.sv
// rtl/shift_unit_arbiter.sv - two-requester arbiter over one SLL/SRA datapath; ROUND_ROBIN_EN selects round-robin over fixed priority
module shift_unit_arbiter #(
   parameter int TAG_W = 4,
   parameter int CNT_W = 16
) (
   input logic                 clock,
   input logic                 reset_n,
   shift_unit_arbiter_if.slave bus
);

   logic                    gnt0;
   logic                    gnt1;
   logic                    acc0;
   logic                    acc1;
   logic [31:0]             sel_data;
   logic [4:0]              sel_shamt;
   logic                    sel_op;
   logic [TAG_W-1:0]        sel_tag;
   logic signed [31:0]      sra_res;
   logic [31:0]             shift_res;

`ifdef ROUND_ROBIN_EN
   // last_gnt names the requester that won most recently; reset to 1 so requester 0 wins first
   logic last_gnt;

   // Grant: sole requester wins, contention goes to whoever did not win last
   always_comb begin
      gnt0 = 1'b0;
      gnt1 = 1'b0;
      if (bus.r0_valid && bus.r1_valid) begin
         gnt0 = last_gnt;
         gnt1 = !last_gnt;
      end else begin
         gnt0 = bus.r0_valid;
         gnt1 = bus.r1_valid;
      end
   end

   // Pointer moves only when an operation is actually accepted
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         last_gnt <= 1'b1;
      end else if (acc0) begin
         last_gnt <= 1'b0;
      end else if (acc1) begin
         last_gnt <= 1'b1;
      end
   end
`else
   // Grant: requester 0 always wins contention; requester 1 only when 0 is idle
   always_comb begin
      gnt0 = bus.r0_valid;
      gnt1 = bus.r1_valid && !bus.r0_valid;
   end
`endif

   assign bus.r0_ready = gnt0;
   assign bus.r1_ready = gnt1;
   assign acc0         = bus.r0_valid && gnt0;
   assign acc1         = bus.r1_valid && gnt1;

   // Steer the winning requester's operation onto the shared shifter
   always_comb begin
      sel_data  = bus.r0_data;
      sel_shamt = bus.r0_shamt;
      sel_op    = bus.r0_op;
      sel_tag   = bus.r0_tag;
      if (gnt1) begin
         sel_data  = bus.r1_data;
         sel_shamt = bus.r1_shamt;
         sel_op    = bus.r1_op;
         sel_tag   = bus.r1_tag;
      end
   end

   // op 0 = logical left (zero fill), op 1 = arithmetic right (sign fill)
   assign sra_res   = $signed(sel_data) >>> sel_shamt;
   assign shift_res = sel_op ? sra_res : (sel_data << sel_shamt);

   // Register result and tag; response pulse is exactly the cycle after acceptance
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         bus.rsp0_valid <= 1'b0;
         bus.rsp1_valid <= 1'b0;
         bus.rsp_data   <= '0;
         bus.rsp_tag    <= '0;
      end else begin
         bus.rsp0_valid <= acc0;
         bus.rsp1_valid <= acc1;
         if (acc0 || acc1) begin
            bus.rsp_data <= shift_res;
            bus.rsp_tag  <= sel_tag;
         end
      end
   end

   // Saturating per-requester acceptance counters
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         bus.gnt_cnt0 <= '0;
         bus.gnt_cnt1 <= '0;
      end else begin
         if (acc0 && !(&bus.gnt_cnt0)) begin
            bus.gnt_cnt0 <= bus.gnt_cnt0 + CNT_W'(1);
         end
         if (acc1 && !(&bus.gnt_cnt1)) begin
            bus.gnt_cnt1 <= bus.gnt_cnt1 + CNT_W'(1);
         end
      end
   end

endmodule

// File: tb/tb_shift_unit_arbiter.sv
// tb/tb_shift_unit_arbiter.sv - directed self-checking bench for shift_unit_arbiter
module tb_shift_unit_arbiter;

   logic clock;
   logic reset_n;
   int   checks;
   int   failures;

   shift_unit_arbiter_if #(.TAG_W(4), .CNT_W(16)) bus ();
   shift_unit_arbiter_if #(.TAG_W(4), .CNT_W(2))  bus_s ();

   shift_unit_arbiter #(.TAG_W(4), .CNT_W(16)) dut (
      .clock   (clock),
      .reset_n (reset_n),
      .bus     (bus)
   );

   shift_unit_arbiter #(.TAG_W(4), .CNT_W(2)) dut_s (
      .clock   (clock),
      .reset_n (reset_n),
      .bus     (bus_s)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic idle_inputs();
      bus.r0_valid = 1'b0; bus.r0_data = '0; bus.r0_shamt = '0; bus.r0_op = 1'b0; bus.r0_tag = '0;
      bus.r1_valid = 1'b0; bus.r1_data = '0; bus.r1_shamt = '0; bus.r1_op = 1'b0; bus.r1_tag = '0;
      bus_s.r0_valid = 1'b0; bus_s.r0_data = '0; bus_s.r0_shamt = '0; bus_s.r0_op = 1'b0; bus_s.r0_tag = '0;
      bus_s.r1_valid = 1'b0; bus_s.r1_data = '0; bus_s.r1_shamt = '0; bus_s.r1_op = 1'b0; bus_s.r1_tag = '0;
   endtask

   task automatic do_reset();
      reset_n = 1'b0;
      idle_inputs();
      repeat (2) @(posedge clock);
      @(negedge clock);
      reset_n = 1'b1;
   endtask

   task automatic test_reset();
      do_reset();
      #1;
      checks++;
      if (bus.rsp0_valid !== 1'b0 || bus.rsp1_valid !== 1'b0) begin
         failures++;
         $display("FAIL reset_valid: rsp0=%b rsp1=%b expected 0 0", bus.rsp0_valid, bus.rsp1_valid);
      end
      checks++;
      if (bus.rsp_data !== 32'h0 || bus.rsp_tag !== 4'h0) begin
         failures++;
         $display("FAIL reset_data: data=%h tag=%h expected 0 0", bus.rsp_data, bus.rsp_tag);
      end
      checks++;
      if (bus.gnt_cnt0 !== 16'h0 || bus.gnt_cnt1 !== 16'h0) begin
         failures++;
         $display("FAIL reset_cnt: cnt0=%0d cnt1=%0d expected 0 0", bus.gnt_cnt0, bus.gnt_cnt1);
      end
      checks++;
      if (bus.r0_ready !== 1'b0 || bus.r1_ready !== 1'b0) begin
         failures++;
         $display("FAIL idle_ready: r0_ready=%b r1_ready=%b expected 0 0", bus.r0_ready, bus.r1_ready);
      end
   endtask

   task automatic test_sll();
      @(negedge clock);
      bus.r0_valid = 1'b1; bus.r0_data = 32'h0000_0001; bus.r0_shamt = 5'd4; bus.r0_op = 1'b0; bus.r0_tag = 4'd3;
      #1;
      checks++;
      if (bus.r0_ready !== 1'b1 || bus.r1_ready !== 1'b0) begin
         failures++;
         $display("FAIL sll_ready: r0_ready=%b r1_ready=%b expected 1 0", bus.r0_ready, bus.r1_ready);
      end
      @(posedge clock); #1;
      bus.r0_valid = 1'b0;
      checks++;
      if (bus.rsp0_valid !== 1'b1 || bus.rsp1_valid !== 1'b0 || bus.rsp_data !== 32'h0000_0010 || bus.rsp_tag !== 4'd3) begin
         failures++;
         $display("FAIL sll_rsp: rsp0=%b rsp1=%b data=%h tag=%0d expected 1 0 00000010 3",
                  bus.rsp0_valid, bus.rsp1_valid, bus.rsp_data, bus.rsp_tag);
      end
      @(posedge clock); #1;
      checks++;
      if (bus.rsp0_valid !== 1'b0 || bus.rsp_data !== 32'h0000_0010 || bus.rsp_tag !== 4'd3) begin
         failures++;
         $display("FAIL sll_hold: rsp0=%b data=%h tag=%0d expected 0 00000010 3",
                  bus.rsp0_valid, bus.rsp_data, bus.rsp_tag);
      end
      checks++;
      if (bus.gnt_cnt0 !== 16'd1 || bus.gnt_cnt1 !== 16'd0) begin
         failures++;
         $display("FAIL sll_cnt: cnt0=%0d cnt1=%0d expected 1 0", bus.gnt_cnt0, bus.gnt_cnt1);
      end
   endtask

   task automatic test_sra();
      logic [31:0] din [2];
      logic [31:0] dexp [2];
      din[0] = 32'h8000_0000; dexp[0] = 32'hFFFF_FFFF;
      din[1] = 32'h4000_0000; dexp[1] = 32'h0000_0000;
      for (int i = 0; i < 2; i++) begin
         @(negedge clock);
         bus.r1_valid = 1'b1; bus.r1_data = din[i]; bus.r1_shamt = 5'd31; bus.r1_op = 1'b1; bus.r1_tag = 4'(5 + i);
         #1;
         checks++;
         if (bus.r1_ready !== 1'b1 || bus.r0_ready !== 1'b0) begin
            failures++;
            $display("FAIL sra_ready%0d: r1_ready=%b r0_ready=%b expected 1 0", i, bus.r1_ready, bus.r0_ready);
         end
         @(posedge clock); #1;
         bus.r1_valid = 1'b0;
         checks++;
         if (bus.rsp1_valid !== 1'b1 || bus.rsp0_valid !== 1'b0 || bus.rsp_data !== dexp[i] || bus.rsp_tag !== 4'(5 + i)) begin
            failures++;
            $display("FAIL sra_rsp%0d: rsp1=%b rsp0=%b data=%h tag=%0d expected 1 0 %h %0d",
                     i, bus.rsp1_valid, bus.rsp0_valid, bus.rsp_data, bus.rsp_tag, dexp[i], 5 + i);
         end
      end
   endtask

   task automatic test_shamt_edges();
      logic [31:0] din [3];
      logic [4:0]  sh [3];
      logic        op [3];
      logic [31:0] dexp [3];
      din[0] = 32'hDEAD_BEEF; sh[0] = 5'd0;  op[0] = 1'b0; dexp[0] = 32'hDEAD_BEEF;
      din[1] = 32'hDEAD_BEEF; sh[1] = 5'd0;  op[1] = 1'b1; dexp[1] = 32'hDEAD_BEEF;
      din[2] = 32'h0000_0003; sh[2] = 5'd31; op[2] = 1'b0; dexp[2] = 32'h8000_0000;
      for (int i = 0; i < 3; i++) begin
         @(negedge clock);
         bus.r0_valid = 1'b1; bus.r0_data = din[i]; bus.r0_shamt = sh[i]; bus.r0_op = op[i]; bus.r0_tag = 4'(9 + i);
         @(posedge clock); #1;
         bus.r0_valid = 1'b0;
         checks++;
         if (bus.rsp0_valid !== 1'b1 || bus.rsp_data !== dexp[i] || bus.rsp_tag !== 4'(9 + i)) begin
            failures++;
            $display("FAIL shamt_edge%0d: rsp0=%b data=%h tag=%0d expected 1 %h %0d",
                     i, bus.rsp0_valid, bus.rsp_data, bus.rsp_tag, dexp[i], 9 + i);
         end
      end
   endtask

   task automatic test_back_to_back();
      logic exp_g1 [4];
      int   exp_c0;
      int   exp_c1;
`ifdef ROUND_ROBIN_EN
      exp_g1[0] = 1'b0; exp_g1[1] = 1'b1; exp_g1[2] = 1'b0; exp_g1[3] = 1'b1;
      exp_c0 = 2; exp_c1 = 2;
`else
      exp_g1[0] = 1'b0; exp_g1[1] = 1'b0; exp_g1[2] = 1'b0; exp_g1[3] = 1'b0;
      exp_c0 = 4; exp_c1 = 0;
`endif
      do_reset();
      bus.r0_valid = 1'b1; bus.r0_data = 32'h0000_0001; bus.r0_shamt = 5'd1; bus.r0_op = 1'b0; bus.r0_tag = 4'd1;
      bus.r1_valid = 1'b1; bus.r1_data = 32'h0000_0100; bus.r1_shamt = 5'd4; bus.r1_op = 1'b1; bus.r1_tag = 4'd2;
      for (int i = 0; i < 4; i++) begin
         #1;
         checks++;
         if (bus.r0_ready !== !exp_g1[i] || bus.r1_ready !== exp_g1[i]) begin
            failures++;
            $display("FAIL b2b_grant%0d: r0_ready=%b r1_ready=%b expected %b %b",
                     i, bus.r0_ready, bus.r1_ready, !exp_g1[i], exp_g1[i]);
         end
         @(posedge clock); #1;
         checks++;
         if (bus.rsp0_valid !== !exp_g1[i] || bus.rsp1_valid !== exp_g1[i] ||
             bus.rsp_data !== (exp_g1[i] ? 32'h0000_0010 : 32'h0000_0002) ||
             bus.rsp_tag !== (exp_g1[i] ? 4'd2 : 4'd1)) begin
            failures++;
            $display("FAIL b2b_rsp%0d: rsp0=%b rsp1=%b data=%h tag=%0d expected rsp1=%b",
                     i, bus.rsp0_valid, bus.rsp1_valid, bus.rsp_data, bus.rsp_tag, exp_g1[i]);
         end
         @(negedge clock);
      end
      idle_inputs();
      #1;
      checks++;
      if (int'(bus.gnt_cnt0) != exp_c0 || int'(bus.gnt_cnt1) != exp_c1) begin
         failures++;
         $display("FAIL b2b_cnt: cnt0=%0d cnt1=%0d expected %0d %0d", bus.gnt_cnt0, bus.gnt_cnt1, exp_c0, exp_c1);
      end
   endtask

   task automatic test_reset_mid();
      do_reset();
      bus.r0_valid = 1'b1; bus.r0_data = 32'h0000_0007; bus.r0_shamt = 5'd2; bus.r0_op = 1'b0; bus.r0_tag = 4'd6;
      @(posedge clock); #1;
      bus.r0_valid = 1'b0;
      checks++;
      if (bus.rsp0_valid !== 1'b1 || bus.rsp_data !== 32'h0000_001C) begin
         failures++;
         $display("FAIL mid_pre: rsp0=%b data=%h expected 1 0000001c", bus.rsp0_valid, bus.rsp_data);
      end
      reset_n = 1'b0;
      #1;
      checks++;
      if (bus.rsp0_valid !== 1'b0 || bus.rsp_data !== 32'h0 || bus.gnt_cnt0 !== 16'd0 || bus.gnt_cnt1 !== 16'd0) begin
         failures++;
         $display("FAIL mid_async: rsp0=%b data=%h cnt0=%0d cnt1=%0d expected 0 0 0 0",
                  bus.rsp0_valid, bus.rsp_data, bus.gnt_cnt0, bus.gnt_cnt1);
      end
      @(posedge clock);
      @(negedge clock);
      reset_n = 1'b1;
      @(posedge clock); #1;
      checks++;
      if (bus.rsp0_valid !== 1'b0 || bus.rsp1_valid !== 1'b0) begin
         failures++;
         $display("FAIL mid_release: rsp0=%b rsp1=%b expected 0 0", bus.rsp0_valid, bus.rsp1_valid);
      end
      bus.r0_valid = 1'b1;
      bus.r1_valid = 1'b1;
      #1;
      checks++;
      if (bus.r0_ready !== 1'b1 || bus.r1_ready !== 1'b0) begin
         failures++;
         $display("FAIL mid_first_contention: r0_ready=%b r1_ready=%b expected 1 0", bus.r0_ready, bus.r1_ready);
      end
      @(negedge clock);
      idle_inputs();
   endtask

   task automatic test_saturation();
      logic [1:0] exp_cnt [5];
      exp_cnt[0] = 2'd1; exp_cnt[1] = 2'd2; exp_cnt[2] = 2'd3; exp_cnt[3] = 2'd3; exp_cnt[4] = 2'd3;
      do_reset();
      bus_s.r0_valid = 1'b1; bus_s.r0_data = 32'h1; bus_s.r0_shamt = 5'd0; bus_s.r0_op = 1'b0; bus_s.r0_tag = 4'd0;
      for (int i = 0; i < 5; i++) begin
         @(posedge clock); #1;
         checks++;
         if (bus_s.gnt_cnt0 !== exp_cnt[i] || bus_s.gnt_cnt1 !== 2'd0) begin
            failures++;
            $display("FAIL sat_cnt%0d: cnt0=%0d cnt1=%0d expected %0d 0", i, bus_s.gnt_cnt0, bus_s.gnt_cnt1, exp_cnt[i]);
         end
      end
      @(negedge clock);
      idle_inputs();
   endtask

   initial begin
      checks   = 0;
      failures = 0;
      reset_n  = 1'b0;
      idle_inputs();
      test_reset();
      test_sll();
      test_sra();
      test_shamt_edges();
      test_back_to_back();
      test_reset_mid();
      test_saturation();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

endmodule
